mem_read_arbiter: RTL and testbench

- Shares one AXI-style memory read channel (AR + R, burst, in-order) between the instruction cache and the data-side requester (D-cache or uncached load path).
- Sits between the cache masters and the bus interface/RAM model.
- Grants one requester at a time, forwards its address phase, and routes the returned burst back to it until the last beat.
- Checks that the beat count matches the requested length.

---
 rtl/mem_read_arbiter_if.sv | 18 +
 rtl/mem_read_arbiter.sv | 81 ++++++++
 tb/tb_mem_read_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: AXI-style read channel (AR address phase + in-order R burst).
// The requester side uses the master modport and the memory side uses the slave modport.
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rlast;
    logic              rready;
    modport master (output araddr, arlen, arvalid, rready, input arready, rdata, rvalid, rlast);
    modport slave  (input araddr, arlen, arvalid, rready, output arready, rdata, rvalid, rlast);
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one burst read channel between the inst (i) and data (d) requesters.
// Fixed priority d over i by default; define ARB_RR_EN for round-robin on simultaneous requests.
module mem_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_read_arbiter_if.slave    i,
    mem_read_arbiter_if.slave    d,
    mem_read_arbiter_if.master   m,
    output logic                 busy,
    output logic                 proto_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t           state;
    logic             gnt_d;
    logic             pick_d;
    logic             in_data;
    logic             beat;
    logic [LEN_W-1:0] cnt;
`ifdef ARB_RR_EN
    logic             last_d;
    // only a contested cycle consults history; a lone requester always wins
    assign pick_d = d.arvalid && !(i.arvalid && last_d);
`else
    assign pick_d = d.arvalid;
`endif
    assign in_data   = state == DATA;
    assign beat      = in_data && m.rvalid && m.rready;
    assign busy      = state != IDLE;
    assign i.arready = state == ADDR && !gnt_d && m.arvalid && m.arready;
    assign d.arready = state == ADDR && gnt_d && m.arvalid && m.arready;
    assign i.rvalid  = in_data && !gnt_d && m.rvalid;
    assign d.rvalid  = in_data && gnt_d && m.rvalid;
    assign i.rlast   = in_data && !gnt_d && m.rlast;
    assign d.rlast   = in_data && gnt_d && m.rlast;
    assign i.rdata   = in_data && !gnt_d ? m.rdata : {DATA_W{1'b0}};
    assign d.rdata   = in_data && gnt_d ? m.rdata : {DATA_W{1'b0}};
    assign m.rready  = in_data && (gnt_d ? d.rready : i.rready);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            m.arvalid <= 1'b0;
            m.araddr  <= {ADDR_W{1'b0}};
            m.arlen   <= {LEN_W{1'b0}};
            cnt       <= {LEN_W{1'b0}};
            proto_err <= 1'b0;
`ifdef ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (i.arvalid || d.arvalid) begin
                    gnt_d     <= pick_d;
                    m.araddr  <= pick_d ? d.araddr : i.araddr;
                    m.arlen   <= pick_d ? d.arlen : i.arlen;
                    m.arvalid <= 1'b1;
                    cnt       <= {LEN_W{1'b0}};
                    state     <= ADDR;
`ifdef ARB_RR_EN
                    last_d    <= pick_d;
`endif
                end
                ADDR: if (m.arready) begin
                    m.arvalid <= 1'b0;
                    state     <= DATA;
                end
                DATA: if (beat) begin
                    cnt <= cnt + LEN_W'(1);
                    // error when rlast and the final expected beat disagree
                    if ((cnt == m.arlen) != m.rlast) proto_err <= 1'b1;
                    if (m.rlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed vector table plus hand sequences against a burst memory model.
// Memory returns beat k of a burst at address A as data A + 4*k.
module tb_mem_read_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, proto_err;
    mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) i_bus ();
    mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) d_bus ();
    mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) m_bus ();

    mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .i(i_bus), .d(d_bus), .m(m_bus),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // memory model
    int          mem_early = 0;
    int          mem_k = 0;
    int          mem_nb = 0;
    bit          mem_busy = 0;
    logic [31:0] mem_addr = 0;
    bit          ar_fire, r_fire;
    logic [31:0] cap_addr;
    logic [3:0]  cap_len;
    initial begin
        m_bus.arready = 0; m_bus.rvalid = 0; m_bus.rlast = 0; m_bus.rdata = 0;
        forever begin
            @(negedge clk);
            ar_fire  = !rst && m_bus.arvalid && m_bus.arready;
            r_fire   = !rst && m_bus.rvalid && m_bus.rready;
            cap_addr = m_bus.araddr;
            cap_len  = m_bus.arlen;
            @(posedge clk);
            #1;
            if (rst) mem_busy = 0;
            else if (ar_fire) begin
                mem_busy = 1; mem_k = 0; mem_addr = cap_addr;
                mem_nb = mem_early > 0 ? mem_early : int'(cap_len) + 1;
            end else if (r_fire) begin
                mem_k++;
                if (mem_k == mem_nb) mem_busy = 0;
            end
            m_bus.arready = !rst && !mem_busy;
            m_bus.rvalid  = mem_busy;
            m_bus.rlast   = mem_busy && mem_k == mem_nb - 1;
            m_bus.rdata   = mem_busy ? mem_addr + 32'(4 * mem_k) : 32'h0;
        end
    end

    // requester-side monitor
    bit          order[$];
    logic [31:0] i_base, d_base;
    int          i_len, d_len, i_beat, d_beat;
    int          i_beats = 0, d_beats = 0, i_bursts = 0, d_bursts = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (i_bus.arready || d_bus.arready) begin
                check("ar_coincide", m_bus.arvalid && m_bus.arready, 1);
                check("ar_one_winner", i_bus.arready && d_bus.arready, 0);
                if (d_bus.arready) begin
                    order.push_back(1); d_base = d_bus.araddr; d_len = int'(d_bus.arlen); d_beat = 0;
                end else begin
                    order.push_back(0); i_base = i_bus.araddr; i_len = int'(i_bus.arlen); i_beat = 0;
                end
            end
            if (m_bus.rvalid && order.size() > 0) begin
                check("rvalid_route", {i_bus.rvalid, d_bus.rvalid}, order[$] ? 2'b01 : 2'b10);
                check("rready_route", m_bus.rready, order[$] ? d_bus.rready : i_bus.rready);
            end
            if (i_bus.rvalid && i_bus.rready) begin
                check("i_rdata", i_bus.rdata, i_base + 32'(4 * i_beat));
                check("i_rlast", i_bus.rlast, i_beat == (mem_early > 0 ? mem_early - 1 : i_len));
                i_beat++; i_beats++;
                if (i_bus.rlast) i_bursts++;
            end
            if (d_bus.rvalid && d_bus.rready) begin
                check("d_rdata", d_bus.rdata, d_base + 32'(4 * d_beat));
                check("d_rlast", d_bus.rlast, d_beat == (mem_early > 0 ? mem_early - 1 : d_len));
                d_beat++; d_beats++;
                if (d_bus.rlast) d_bursts++;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit is_d, input logic [31:0] a, input logic [3:0] l, output int n);
        n = 0;
        if (is_d) begin d_bus.araddr = a; d_bus.arlen = l; d_bus.arvalid = 1; end
        else begin i_bus.araddr = a; i_bus.arlen = l; i_bus.arvalid = 1; end
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_bus.arready : i_bus.arready) && n < 300);
        check("ar_hs", is_d ? d_bus.arready : i_bus.arready, 1);
        step;
        if (is_d) d_bus.arvalid = 0;
        else i_bus.arvalid = 0;
    endtask

    task automatic wait_done(input int ti, input int td);
        int n = 0;
        while ((i_bursts < ti || d_bursts < td) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("burst_done", i_bursts >= ti && d_bursts >= td, 1);
        @(negedge clk);
        check("busy_idle", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_i"}, {i_bus.arready, i_bus.rvalid, i_bus.rlast, i_bus.rdata}, 0);
        check({tag, "_d"}, {d_bus.arready, d_bus.rvalid, d_bus.rlast, d_bus.rdata}, 0);
        check({tag, "_m"}, {m_bus.arvalid, m_bus.araddr, m_bus.arlen, m_bus.rready}, 0);
        check({tag, "_status"}, {busy, proto_err}, 0);
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [3:0]  len;
        int          beats;
        bit          err;
    } vec_t;
    vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n0, n1, n2, ob, ib, db, bi, bd;
    initial begin
        vt[0] = '{0, 32'hf0000000, 4'd7, 8, 0};
        vt[1] = '{1, 32'h1fc00010, 4'd0, 1, 0};
        vt[2] = '{1, 32'h80000040, 4'd3, 4, 0};
        vt[3] = '{0, 32'h00001000, 4'd15, 16, 0};
        vt[4] = '{1, 32'h00002000, 4'd1, 2, 0};
        i_bus.araddr = 0; i_bus.arlen = 0; i_bus.arvalid = 0; i_bus.rready = 1;
        d_bus.araddr = 0; d_bus.arlen = 0; d_bus.arvalid = 0; d_bus.rready = 1;
        #2 rst = 1;
        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        step;

        // simultaneous requests: d wins first in both arbitration modes after reset
        ob = order.size(); bi = i_bursts; bd = d_bursts;
        fork
            req(0, 32'hf1000004, 4'd7, n0);
            req(1, 32'h80000000, 4'd0, n1);
        join
        wait_done(bi + 1, bd + 1);
        check("sim_first", order[ob], 1);
        check("sim_second", order[ob + 1], 0);
        step;

        // d re-requests while i waits: fixed gives d,d,i and round-robin gives d,i,d
        ob = order.size(); bi = i_bursts; bd = d_bursts;
        fork
            begin
                req(1, 32'h80000100, 4'd1, n0);
                req(1, 32'h80000200, 4'd1, n1);
            end
            req(0, 32'h00000300, 4'd0, n2);
        join
        wait_done(bi + 1, bd + 2);
`ifdef ARB_RR_EN
        check("arb_order", {order[ob], order[ob + 1], order[ob + 2]}, 3'b101);
`else
        check("arb_order", {order[ob], order[ob + 1], order[ob + 2]}, 3'b110);
`endif
        step;

        for (int k = 0; k < 5; k++) begin
            ib = i_beats; db = d_beats; ob = order.size(); bi = i_bursts; bd = d_bursts;
            req(vt[k].is_d, vt[k].addr, vt[k].len, n0);
            check("hs_latency", n0, 2);
            wait_done(bi + (vt[k].is_d ? 0 : 1), bd + (vt[k].is_d ? 1 : 0));
            check("beats", vt[k].is_d ? d_beats - db : i_beats - ib, vt[k].beats);
            check("grant", order[ob], vt[k].is_d);
            check("grants_n", order.size() - ob, 1);
            check("proto_err", proto_err, vt[k].err);
            step;
        end

        // backpressure mid-burst
        ib = i_beats; bi = i_bursts;
        req(0, 32'h00003000, 4'd7, n0);
        n1 = 0;
        while (i_beat < 3 && n1 < 100) begin
            @(negedge clk);
            n1++;
        end
        check("bp_reach", i_beat >= 3, 1);
        step;
        i_bus.rready = 0;
        repeat (3) begin
            @(negedge clk);
            check("bp_m_rready", m_bus.rready, 0);
            check("bp_rvalid_held", i_bus.rvalid, 1);
        end
        step;
        i_bus.rready = 1;
        wait_done(bi + 1, d_bursts);
        check("bp_beats", i_beats - ib, 8);
        check("bp_proto_err", proto_err, 0);
        step;

        // early rlast at beat 5 of an 8-beat burst
        mem_early = 5;
        ib = i_beats; bi = i_bursts;
        req(0, 32'h00004000, 4'd7, n0);
        wait_done(bi + 1, d_bursts);
        check("early_beats", i_beats - ib, 5);
        check("early_err", proto_err, 1);
        mem_early = 0;
        step;
        bd = d_bursts;
        req(1, 32'h00004100, 4'd0, n0);
        wait_done(i_bursts, bd + 1);
        check("err_sticky", proto_err, 1);
        step;

        // asynchronous reset in the middle of a burst
        req(0, 32'h00005000, 4'd7, n0);
        n1 = 0;
        while (i_beat < 2 && n1 < 100) begin
            @(negedge clk);
            n1++;
        end
        @(posedge clk);
        #3 rst = 1;
        #1 check_zero("midrst");
        ib = i_beats;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        repeat (3) step;
        check("no_beats_after_rst", i_beats - ib, 0);
        db = d_beats; bd = d_bursts;
        req(1, 32'h00006000, 4'd1, n0);
        check("post_rst_latency", n0, 2);
        wait_done(i_bursts, bd + 1);
        check("post_rst_beats", d_beats - db, 2);
        check("post_rst_err", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
